// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode, ALU OP and sequencer state encodings shared by the ALU front-end
package alu_pkg;
  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADC  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;
  localparam logic [1:0] ALU_ZERO = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ISSUE   = 2'b01,
    CAPTURE = 2'b10,
    RESP    = 2'b11
  } seq_state_e;
endpackage

// File: rtl/alu8.sv
// rtl/alu8.sv - combinational ALU: Y=A / A+B+CY / A-B / 0, ST = signed overflow
module alu8
  import alu_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          cy,
  input  logic [1:0]    op,
  output logic [DW-1:0] y,
  output logic          st
);
  always_comb begin
    y  = '0;
    st = 1'b0;
    case (op)
      ALU_PASS: y = a;
      ALU_ADC: begin
        y  = a + b + {{(DW-1){1'b0}}, cy};
        st = (a[DW-1] == b[DW-1]) && (y[DW-1] != a[DW-1]);
      end
      ALU_SUB: begin
        y  = a - b;
        st = (a[DW-1] != b[DW-1]) && (y[DW-1] != a[DW-1]);
      end
      default: y = '0;
    endcase
  end
endmodule

// File: rtl/alu_cmd_decode.sv
// rtl/alu_cmd_decode.sv - maps a command onto the next ALU A/B/CY/OP operand set
module alu_cmd_decode
  import alu_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [1:0]    cmd_op,
  input  logic [DW-1:0] cmd_data,
  input  logic [DW-1:0] acc,
  input  logic          st_flag,
  input  logic          cmd_use_cy,
  output logic [DW-1:0] a_d,
  output logic [DW-1:0] b_d,
  output logic          cy_d,
  output logic [1:0]    op_d
);
  always_comb begin
    a_d  = '0;
    b_d  = '0;
    cy_d = 1'b0;
    op_d = ALU_ZERO;
    case (cmd_op)
      OP_LOAD: begin
        a_d  = cmd_data;
        op_d = ALU_PASS;
      end
      OP_ADD: begin
        a_d  = acc;
        b_d  = cmd_data;
        cy_d = cmd_use_cy & st_flag;
        op_d = ALU_ADC;
      end
      OP_SUB: begin
        a_d  = acc;
        b_d  = cmd_data;
        op_d = ALU_SUB;
      end
      default: op_d = ALU_ZERO;
    endcase
  end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command front-end and writeback stage around an external 8-bit ALU
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [DW-1:0]    cmd_data,
  input  logic             cmd_use_cy,
  output logic [DW-1:0]    alu_a,
  output logic [DW-1:0]    alu_b,
  output logic             alu_cy,
  output logic [1:0]       alu_op,
  input  logic [DW-1:0]    alu_y,
  input  logic             alu_st,
  output logic [DW-1:0]    acc,
  output logic             st_flag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DW-1:0]    rsp_data,
  output logic             rsp_st,
  output logic [CNT_W-1:0] op_count
);
  seq_state_e       state_q, state_d;
  logic [DW-1:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic             alu_cy_q, alu_cy_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic [DW-1:0]    acc_q, acc_d, rsp_data_q, rsp_data_d;
  logic             st_q, st_d, rsp_st_q, rsp_st_d, rsp_valid_q, rsp_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [DW-1:0]    dec_a, dec_b;
  logic             dec_cy;
  logic [1:0]       dec_op;

  alu_cmd_decode #(.DW(DW)) u_decode (
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .acc       (acc_q),
    .st_flag   (st_q),
    .cmd_use_cy(cmd_use_cy),
    .a_d       (dec_a),
    .b_d       (dec_b),
    .cy_d      (dec_cy),
    .op_d      (dec_op)
  );

  // alu_* only change on accept, so they hold their last operands while idle
  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_cy_d    = alu_cy_q;
    alu_op_d    = alu_op_q;
    acc_d       = acc_q;
    st_d        = st_q;
    rsp_data_d  = rsp_data_q;
    rsp_st_d    = rsp_st_q;
    rsp_valid_d = rsp_valid_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          alu_a_d  = dec_a;
          alu_b_d  = dec_b;
          alu_cy_d = dec_cy;
          alu_op_d = dec_op;
          state_d  = ISSUE;
        end
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        acc_d       = alu_y;
        st_d        = alu_st;
        rsp_data_d  = alu_y;
        rsp_st_d    = alu_st;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cnt_d       = cnt_q + CNT_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_cy_q    <= 1'b0;
      alu_op_q    <= '0;
      acc_q       <= '0;
      st_q        <= 1'b0;
      rsp_data_q  <= '0;
      rsp_st_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_cy_q    <= alu_cy_d;
      alu_op_q    <= alu_op_d;
      acc_q       <= acc_d;
      st_q        <= st_d;
      rsp_data_q  <= rsp_data_d;
      rsp_st_q    <= rsp_st_d;
      rsp_valid_q <= rsp_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  // gated with rst so the handshake is closed for the whole reset pulse
  assign cmd_ready = (state_q == IDLE) && !rst;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_cy    = alu_cy_q;
  assign alu_op    = alu_op_q;
  assign acc       = acc_q;
  assign st_flag   = st_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_st    = rsp_st_q;
  assign op_count  = cnt_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - randomized self-checking bench for alu_cmd_sequencer with the ALU attached
module tb_alu_cmd_sequencer;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [7:0]    cmd_data = 8'h00;
  logic          cmd_use_cy = 1'b0;
  logic [7:0]    alu_a, alu_b, alu_y;
  logic          alu_cy, alu_st;
  logic [1:0]    alu_op;
  logic [7:0]    acc, rsp_data;
  logic          st_flag, rsp_valid, rsp_st;
  logic          rsp_ready = 1'b0;
  logic [CW-1:0] op_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  alu_cmd_sequencer #(.DW(8), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_use_cy(cmd_use_cy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cy(alu_cy), .alu_op(alu_op),
    .alu_y(alu_y), .alu_st(alu_st),
    .acc(acc), .st_flag(st_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_st(rsp_st), .op_count(op_count)
  );

  alu8 #(.DW(8)) u_alu (
    .a(alu_a), .b(alu_b), .cy(alu_cy), .op(alu_op), .y(alu_y), .st(alu_st)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return {21'd0, acc, alu_a, alu_b, rsp_data, st_flag, alu_cy, alu_op, rsp_st,
            rsp_valid, cmd_ready, 4'(op_count)};
  endfunction

  // reference model: one command in flight, results from signed arithmetic
  bit         busy = 1'b0;
  int         acc_cyc = 0;
  logic [7:0] m_acc = 8'h00;
  bit         m_st = 1'b0;
  int         m_cnt = 0;
  logic [7:0] e_a, e_b, e_y;
  logic [1:0] e_op;
  bit         e_cy, e_st;
  int         s;

  always @(negedge clk) begin
    if (rst) begin
      chk("reset_outputs", out_vec(), 64'd0);
      busy  = 1'b0;
      m_acc = 8'h00;
      m_st  = 1'b0;
      m_cnt = 0;
    end else begin
      chk("cmd_ready", cmd_ready, !busy);
      chk("op_count", op_count, m_cnt);
      chk("rsp_valid", rsp_valid, busy && (cyc - acc_cyc) >= 3);
      if (busy && (cyc - acc_cyc) == 1)
        chk("alu_inputs", {alu_a, alu_b, alu_cy, alu_op}, {e_a, e_b, e_cy, e_op});
      if (busy && rsp_valid) begin
        chk("rsp_data", rsp_data, e_y);
        chk("rsp_st", rsp_st, e_st);
        chk("acc", acc, e_y);
        chk("st_flag", st_flag, e_st);
      end
      if (busy && rsp_valid && rsp_ready) begin
        busy  = 1'b0;
        m_cnt = (m_cnt + 1) % (1 << CW);
      end
      if (cmd_valid && cmd_ready) begin
        e_op = cmd_op;
        e_a  = (cmd_op == 2'b00) ? cmd_data : (cmd_op == 2'b11) ? 8'h00 : m_acc;
        e_b  = (cmd_op == 2'b01 || cmd_op == 2'b10) ? cmd_data : 8'h00;
        e_cy = (cmd_op == 2'b01) && cmd_use_cy && m_st;
        case (cmd_op)
          2'b00: begin e_y = cmd_data; e_st = 1'b0; end
          2'b01: begin
            s    = int'($signed(m_acc)) + int'($signed(cmd_data)) + int'(e_cy);
            e_y  = s[7:0];
            e_st = (s > 127) || (s < -128);
          end
          2'b10: begin
            s    = int'($signed(m_acc)) - int'($signed(cmd_data));
            e_y  = s[7:0];
            e_st = (s > 127) || (s < -128);
          end
          default: begin e_y = 8'h00; e_st = 1'b0; end
        endcase
        m_acc   = e_y;
        m_st    = e_st;
        busy    = 1'b1;
        acc_cyc = cyc;
      end
    end
  end

  task automatic do_cmd(input logic [1:0] op, input logic [7:0] d, input bit ucy, input int stall,
                        output logic [7:0] rd, output bit rs, output bit cy_o);
    int n;
    @(posedge clk); #1;
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_data   = d;
    cmd_use_cy = ucy;
    rsp_ready  = (stall == 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!cmd_ready && n < 20);
    chk("accept_wait", cmd_ready, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_data  = 8'($urandom);
    @(negedge clk);
    cy_o = alu_cy;
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    chk("rsp_wait", rsp_valid, 1'b1);
    rd = rsp_data;
    rs = rsp_st;
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #1 rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    logic [7:0]    rd;
    logic [CW-1:0] c0;
    bit            rs, cy;
    int            n;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    do_cmd(2'b00, 8'h7F, 1'b0, 0, rd, rs, cy);
    do_cmd(2'b01, 8'h01, 1'b0, 0, rd, rs, cy);
    chk("t1_data", rd, 8'h80);
    chk("t1_st", rs, 1'b1);
    chk("t1_acc", acc, 8'h80);

    do_cmd(2'b00, 8'hFF, 1'b0, 0, rd, rs, cy);
    chk("t2_load_st", rs, 1'b0);
    do_cmd(2'b01, 8'h01, 1'b0, 0, rd, rs, cy);
    chk("t2_wrap_data", rd, 8'h00);
    chk("t2_wrap_st", rs, 1'b0);
    do_cmd(2'b01, 8'h00, 1'b1, 0, rd, rs, cy);
    chk("t2_cy_clear", cy, 1'b0);
    do_cmd(2'b00, 8'h7F, 1'b0, 0, rd, rs, cy);
    do_cmd(2'b01, 8'h01, 1'b0, 0, rd, rs, cy);
    chk("t2_ovf_st", rs, 1'b1);
    do_cmd(2'b01, 8'h05, 1'b1, 0, rd, rs, cy);
    chk("t2_cy_set", cy, 1'b1);
    chk("t2_cy_data", rd, 8'h86);

    do_cmd(2'b00, 8'h80, 1'b0, 0, rd, rs, cy);
    do_cmd(2'b10, 8'h01, 1'b0, 0, rd, rs, cy);
    chk("t3_sub_data", rd, 8'h7F);
    chk("t3_sub_st", rs, 1'b1);
    do_cmd(2'b10, 8'h7F, 1'b0, 0, rd, rs, cy);
    chk("t3_zero_data", rd, 8'h00);
    chk("t3_zero_st", rs, 1'b0);

    do_cmd(2'b00, 8'h55, 1'b0, 0, rd, rs, cy);
    do_cmd(2'b11, 8'hAA, 1'b0, 0, rd, rs, cy);
    chk("t4_clr_data", rd, 8'h00);
    chk("t4_clr_st", st_flag, 1'b0);

    c0 = op_count;
    do_cmd(2'b00, 8'h33, 1'b0, 5, rd, rs, cy);
    chk("t5_stall_data", rd, 8'h33);
    chk("t5_count", op_count, c0 + 4'd1);
    chk("t5_idle_ready", cmd_ready, 1'b1);

    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_data  = 8'h44;
    n = 0;
    do begin @(negedge clk); n++; end while (!cmd_ready && n < 20);
    chk("t6_accept", cmd_ready, 1'b1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    #1 chk("t6_async_reset", out_vec(), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    do_cmd(2'b00, 8'h12, 1'b0, 0, rd, rs, cy);
    chk("t6_data", rd, 8'h12);
    chk("t6_count", op_count, 4'd1);

    for (int i = 0; i < 300; i++)
      do_cmd(2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom), $urandom_range(0, 3), rd, rs, cy);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
